// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity codes and baud divider math.
// Used by uart_tx and by the receive side.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Cycles per bit; the integer floor is intended.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: emits a one-cycle bit_end tick every DIV cycles, realigned by clr
// at the start of each frame.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == CW'(DIV - 1));

  // NOTE: registers are written with non-blocking assignments so every flop samples
  // the values that existed before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a byte FIFO: start bit, LSB-first data, optional parity,
// 1 or 2 stop bits, one pop strobe per frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);

  uart_state_e          state, state_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic [2:0]           bit_idx, bit_idx_d;
  logic                 stop_idx, stop_idx_d;
  logic                 par_bit, par_bit_d;
  logic                 tx_d, rd_en_d, done_d;
  logic                 start_frame, bit_end;

  assign start_frame = (state == ST_IDLE) && !fifo_empty;
  assign busy        = (state != ST_IDLE);

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_frame),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      bit_idx    <= bit_idx_d;
      stop_idx   <= stop_idx_d;
      par_bit    <= par_bit_d;
      tx         <= tx_d;
      fifo_rd_en <= rd_en_d;
      frame_done <= done_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    par_bit_d  = par_bit;
    tx_d       = tx;
    rd_en_d    = 1'b0;
    done_d     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          shreg_d   = fifo_data[DATA_BITS-1:0];
          // Parity is fixed at capture time since the shift register drains the data.
          par_bit_d = (^fifo_data[DATA_BITS-1:0]) ^ (PARITY == PAR_ODD);
          rd_en_d   = 1'b1;
          tx_d      = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_d      = shreg[0];
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            if (PARITY != PAR_NONE) begin
              tx_d    = par_bit;
              state_d = ST_PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
              state_d    = ST_STOP;
            end
          end else begin
            shreg_d   = shreg >> 1;
            tx_d      = shreg[1];
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains the transmit byte FIFO and shifts each byte onto the UART line. It sits directly downstream of the TX FIFO. It watches the FIFO's `empty` flag, captures the FIFO's registered `data_out`, and issues a single-cycle `rd_en` pop per byte. Each byte is framed LSB-first with a start bit, an optional parity bit and 1 or 2 stop bits, at a fixed baud rate derived from the system clock.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate. The divider is `DIV = CLK_FREQ / BAUD_RATE` (integer floor) and must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame, legal range 5–8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk`, input, 1 bit: clock.
- `rst`, input, 1 bit: reset, synchronous, active-high.
- `fifo_empty`, input, 1 bit: FIFO empty flag.
- `fifo_data`, input, 8 bits: FIFO head byte. Valid whenever `fifo_empty` = 0.
- `fifo_rd_en`, output, 1 bit: registered one-cycle pop strobe to the FIFO.
- `tx`, output, 1 bit: serial line, registered, idles high.
- `busy`, output, 1 bit: high while a frame is in progress.
- `frame_done`, output, 1 bit: one-cycle pulse when a stop bit completes.

## Operation
- Reset values: `tx` = 1, `fifo_rd_en` = 0, `busy` = 0, `frame_done` = 0, state = IDLE, all counters = 0.
- States: IDLE → START → DATA → PARITY (skipped when `PARITY` = 0) → STOP → IDLE.
- IDLE:
  - If `fifo_empty` = 0 at a clock edge, on that edge:
    - latch `fifo_data[DATA_BITS-1:0]` into the shift register;
    - set `fifo_rd_en` to 1;
    - drive `tx` to 0;
    - clear the baud counter;
    - move to START.
  - Otherwise hold `tx` = 1.
- `fifo_rd_en` is high for exactly one cycle per byte and is never asserted outside the IDLE→START edge.
- A pop is never requested while `fifo_empty` = 1.
- Each bit lasts exactly `DIV` cycles. The baud counter counts 0..DIV-1, and the bit ends when the counter reaches DIV-1.
- START: at bit end, drive `tx` = shreg[0] and go to DATA with bit index 0.
- DATA:
  - At each bit end, shift right and increment the bit index.
  - After bit `DATA_BITS-1`, go to PARITY with `tx` = parity bit, or to STOP with `tx` = 1.
- Parity bit:
  - even: XOR of the data bits;
  - odd: the inverse of that XOR.
- STOP:
  - `tx` = 1 for `STOP_BITS*DIV` cycles.
  - At the end, pulse `frame_done` and return to IDLE.
- `busy` = 1 in every state except IDLE.
- Reset mid-frame: on the next edge every output returns to its reset value and the frame is abandoned. The already-popped byte is lost and is not re-popped.

## Timing
- Frame length `F` = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV cycles, from the edge where `tx` falls to the edge where the state re-enters IDLE.
- Pop latency: `fifo_empty` low sampled at edge k → `fifo_rd_en` high during cycle k..k+1 → the FIFO pops at edge k+1.
- Back-to-back frames, FIFO never empty: consecutive `fifo_rd_en` pulses are exactly F+1 cycles apart. One idle-high cycle is inserted between frames.
- `fifo_data` is sampled only in IDLE, at least F cycles after the previous pop, so the FIFO's registered `data_out` has settled.
- `fifo_empty` falling while busy has no effect until IDLE.

## Structure
- Shared package `uart_pkg`:
  - the state encoding (IDLE, START, DATA, PARITY, STOP);
  - the parity codes `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - the function computing `DIV` from `CLK_FREQ`/`BAUD_RATE`.
  - This package is shared with the future `uart_rx`.
- Sub-module `uart_baud_gen`: a counter with synchronous clear (asserted on frame start) that emits a one-cycle `bit_end` tick every `DIV` cycles.

## Test plan
Unless noted, use `CLK_FREQ` = 160, `BAUD_RATE` = 10 (DIV = 16), 8N1.
- **Single byte.** Present 0x55 with `fifo_empty` = 0.
  - Expect exactly one `fifo_rd_en` pulse.
  - `tx` bits, each 16 cycles wide: 0,1,0,1,0,1,0,1,0,1.
  - `frame_done` at cycle 160; `busy` high for 160 cycles.
- **Parity.** Send 0x07.
  - `PARITY` = 2 → parity bit 1.
  - `PARITY` = 1 → parity bit 0.
  - Frame length 176 cycles.
- **Back-to-back, 2 stop bits.** Queue 0xA5 then 0x3C with `STOP_BITS` = 2.
  - Two `fifo_rd_en` pulses 177 cycles apart.
  - 33 consecutive high cycles on `tx` between the frames.
- **Empty FIFO.** Hold `fifo_empty` = 1 for 1000 cycles.
  - `tx` stays 1, `fifo_rd_en` stays 0, `busy` stays 0.
- **Reset mid-frame.** Assert `rst` during DATA bit 3 of 0xFF.
  - Next edge: `tx` = 1, `busy` = 0, `fifo_rd_en` = 0.
  - After release with the FIFO still non-empty, a fresh full frame starts with a new single pop.
- **5-bit frames.** `DATA_BITS` = 5, send 0x1F with the upper bits 0xE0 set.
  - Only 5 ones are transmitted.
  - Frame length 7×16 = 112 cycles.
